// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared encodings for the LED mode/colour control block.
package led_ctrl_pkg;

    // Working modes of the pattern datapath; encoding 3 is never entered on purpose.
    typedef enum logic [1:0] {
        MODE_FLASH   = 2'd0,
        MODE_SHIFT   = 2'd1,
        MODE_SHIFT2  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    // Colour selection for the RGB output stage.
    typedef enum logic [1:0] {
        COLOR_RED   = 2'd0,
        COLOR_GREEN = 2'd1,
        COLOR_BLUE  = 2'd2
    } color_t;

    // Positions of the push-buttons within the button vector.
    localparam int BTN_MODE  = 0;
    localparam int BTN_RED   = 1;
    localparam int BTN_GREEN = 2;
    localparam int BTN_BLUE  = 3;

    // Mode sequence FLASH -> SHIFT -> SHIFT2 -> FLASH; the illegal code recovers to FLASH.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_FLASH: next_mode = MODE_SHIFT;
            MODE_SHIFT: next_mode = MODE_SHIFT2;
            default:    next_mode = MODE_FLASH;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus level debouncer for one push-button.
module btn_debounce #(
    parameter int NB_DEBOUNCE  = 20,
    parameter int DEBOUNCE_MAX = 1000000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_stable
);

    localparam logic [NB_DEBOUNCE-1:0] COUNT_LAST = NB_DEBOUNCE'(DEBOUNCE_MAX - 1);

    logic                   sync_meta;
    logic                   sync_level;
    logic                   stable;
    logic [NB_DEBOUNCE-1:0] count;

    // Bring the asynchronous button level into the clock domain.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= i_btn;
            sync_level <= sync_meta;
        end
    end

    // Accept a new level only after DEBOUNCE_MAX consecutive differing samples.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync_level == stable) begin
            count <= '0;
        end else if (count == COUNT_LAST) begin
            stable <= sync_level;
            count  <= '0;
        end else begin
            count <= count + NB_DEBOUNCE'(1);
        end
    end

    assign o_stable = stable;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced buttons -> mode FSM, auto-advance and colour select.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NB_SW        = 4,
    parameter int NB_DEBOUNCE  = 20,
    parameter int DEBOUNCE_MAX = 1000000,
    parameter int NB_AUTO      = 5,
    parameter int AUTO_TICKS   = 16
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_btn,
    input  logic             i_valid,
    input  logic             i_auto,
    output logic [1:0]       o_mode,
    output logic [1:0]       o_color,
    output logic             o_clear,
    output logic [NB_SW-1:0] o_btn_db
);

    localparam logic [NB_AUTO-1:0] AUTO_LAST = NB_AUTO'(AUTO_TICKS - 1);

    logic [NB_SW-1:0]   btn_db;
    logic [NB_SW-1:0]   btn_db_q;
    logic [NB_SW-1:0]   rise;
    logic [NB_AUTO-1:0] auto_cnt;
    logic               auto_fire;
    logic               advance;
    mode_t              state_q;
    mode_t              state_d;
    logic               clear_d;
    logic               clear_q;
    color_t             color_q;
    color_t             color_d;

    for (genvar gi = 0; gi < NB_SW; gi++) begin : g_btn
        btn_debounce #(
            .NB_DEBOUNCE  (NB_DEBOUNCE),
            .DEBOUNCE_MAX (DEBOUNCE_MAX)
        ) u_debounce (
            .clock    (clock),
            .i_reset  (i_reset),
            .i_btn    (i_btn[gi]),
            .o_stable (btn_db[gi])
        );
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            btn_db_q <= '0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign rise      = btn_db & ~btn_db_q;
    assign auto_fire = i_auto && i_valid && (auto_cnt == AUTO_LAST);
    assign advance   = rise[BTN_MODE] || auto_fire;

    // Count i_valid ticks while auto mode is on; restart after any advance.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            auto_cnt <= '0;
        end else if (!i_auto || advance) begin
            auto_cnt <= '0;
        end else if (i_valid) begin
            auto_cnt <= auto_cnt + NB_AUTO'(1);
        end
    end

    // Next mode and restart pulse; a simultaneous press and auto tick is one step.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (advance || state_q == MODE_ILLEGAL) begin
            state_d = next_mode(state_q);
        end
        clear_d = (state_d != state_q);
    end

    // Mode state register and its companion restart pulse.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= MODE_FLASH;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    // Colour choice: lowest-index colour button pressed this cycle wins.
    always_comb begin
        color_d = color_q;
        if (rise[BTN_RED]) begin
            color_d = COLOR_RED;
        end else if (rise[BTN_GREEN]) begin
            color_d = COLOR_GREEN;
        end else if (rise[BTN_BLUE]) begin
            color_d = COLOR_BLUE;
        end
    end

    // Colour register.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            color_q <= COLOR_RED;
        end else begin
            color_q <= color_d;
        end
    end

    assign o_mode   = state_q;
    assign o_color  = color_q;
    assign o_clear  = clear_q;
    assign o_btn_db = btn_db;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_led_mode_ctrl;

    localparam int NB_SW        = 4;
    localparam int NB_DEBOUNCE  = 20;
    localparam int DEBOUNCE_MAX = 4;
    localparam int NB_AUTO      = 5;
    localparam int AUTO_TICKS   = 3;

    logic             clock   = 1'b0;
    logic             i_reset = 1'b1;
    logic [NB_SW-1:0] i_btn   = '0;
    logic             i_valid = 1'b0;
    logic             i_auto  = 1'b0;
    logic [1:0]       o_mode;
    logic [1:0]       o_color;
    logic             o_clear;
    logic [NB_SW-1:0] o_btn_db;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    led_mode_ctrl #(
        .NB_SW        (NB_SW),
        .NB_DEBOUNCE  (NB_DEBOUNCE),
        .DEBOUNCE_MAX (DEBOUNCE_MAX),
        .NB_AUTO      (NB_AUTO),
        .AUTO_TICKS   (AUTO_TICKS)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_btn    (i_btn),
        .i_valid  (i_valid),
        .i_auto   (i_auto),
        .o_mode   (o_mode),
        .o_color  (o_color),
        .o_clear  (o_clear),
        .o_btn_db (o_btn_db)
    );

    // ---------------- behavioural reference model ----------------
    // Buttons: a level is accepted once the synchronised input (raw delayed by two
    // edges) has disagreed with the accepted level for DEBOUNCE_MAX edges in a row.
    logic [NB_SW-1:0] raw_log[$];
    logic [NB_SW-1:0] m_db      = '0;
    logic [NB_SW-1:0] m_db_prev = '0;
    int               m_mode    = 0;
    int               m_color   = 0;
    int               m_ticks   = 0;
    bit               m_clear   = 1'b0;

    task automatic model_reset();
        raw_log.delete();
        m_db      = '0;
        m_db_prev = '0;
        m_mode    = 0;
        m_color   = 0;
        m_ticks   = 0;
        m_clear   = 1'b0;
    endtask

    task automatic model_edge();
        logic [NB_SW-1:0] press;
        bit               fire;
        bit               adv;
        int               k;
        press = m_db & ~m_db_prev;
        fire  = i_auto && i_valid && (m_ticks == AUTO_TICKS - 1);
        adv   = press[0] || fire;
        m_clear = adv;
        if (adv) m_mode = (m_mode + 1) % 3;
        if (!i_auto || adv) m_ticks = 0;
        else if (i_valid) m_ticks = m_ticks + 1;
        if (press[1]) m_color = 0;
        else if (press[2]) m_color = 1;
        else if (press[3]) m_color = 2;
        raw_log.push_back(i_btn);
        k = raw_log.size() - 1;
        m_db_prev = m_db;
        for (int b = 0; b < NB_SW; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < DEBOUNCE_MAX; j++) begin
                int  idx;
                logic v;
                idx = k - 2 - j;
                v = (idx >= 0) ? raw_log[idx][b] : 1'b0;
                if (v == m_db[b]) all_diff = 1'b0;
            end
            if (all_diff) m_db[b] = ~m_db[b];
        end
    endtask

    initial forever begin
        @(posedge clock or posedge i_reset);
        if (i_reset) model_reset();
        else model_edge();
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("mode",   32'(o_mode),   32'(m_mode));
        check("color",  32'(o_color),  32'(m_color));
        check("clear",  32'(o_clear),  32'(m_clear));
        check("btn_db", 32'(o_btn_db), 32'(m_db));
    endtask

    // One clock cycle: outputs are sampled on the falling edge, then inputs may change.
    task automatic tick();
        @(negedge clock);
        compare_all();
    endtask

    task automatic tick_valid();
        repeat (4) tick();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // Press btn[0] for six raw cycles and measure when the restart pulse appears.
    task automatic press_mode(input int exp_mode);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        i_btn[0] = 1'b1;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 6) i_btn[0] = 1'b0;
            if (o_clear) seen = 1'b1;
        end
        i_btn[0] = 1'b0;
        check("clear_latency", 32'(n), 32'(DEBOUNCE_MAX + 3));
        check("manual_mode", 32'(o_mode), 32'(exp_mode));
        tick();
        check("clear_width", 32'(o_clear), 32'd0);
        repeat (12) tick();
        check("release_no_event", 32'(o_mode), 32'(exp_mode));
    endtask

    task automatic press_color(input logic [NB_SW-1:0] mask, input int exp_color);
        i_btn = mask;
        repeat (6) tick();
        i_btn = '0;
        repeat (10) tick();
        check("color_sel", 32'(o_color), 32'(exp_color));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_db;
        int hold_left[NB_SW];

        // Power-up reset.
        repeat (3) tick();
        check("reset_mode", 32'(o_mode), 32'd0);
        check("reset_clear", 32'(o_clear), 32'd0);
        i_reset = 1'b0;
        repeat (3) tick();

        // Manual cycling through the modes.
        press_mode(1);
        press_mode(2);
        press_mode(0);
        press_mode(1);

        // Colour selection, including a simultaneous red+blue press.
        press_color(4'b0100, 1);
        press_color(4'b1010, 0);
        press_color(4'b1000, 2);

        // Reset in the middle of a debounce count and an auto count.
        i_btn = 4'b1000;
        repeat (8) tick();
        i_auto  = 1'b1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_btn[2] = 1'b1;
        repeat (3) tick();
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_mode",   32'(o_mode),   32'd0);
        check("async_rst_color",  32'(o_color),  32'd0);
        check("async_rst_clear",  32'(o_clear),  32'd0);
        check("async_rst_btn_db", 32'(o_btn_db), 32'd0);
        repeat (2) tick();
        i_reset = 1'b0;
        i_btn   = '0;
        i_auto  = 1'b0;
        repeat (2) tick();
        i_btn[0] = 1'b1;
        repeat (2) tick();
        i_btn[0] = 1'b0;
        repeat (10) tick();
        check("glitch_mode", 32'(o_mode), 32'd0);

        // Automatic cycling every AUTO_TICKS ticks.
        i_auto = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick_valid();
            check("auto_mode", 32'(o_mode), 32'((t / AUTO_TICKS) % 3));
        end
        i_auto = 1'b0;
        repeat (5) tick_valid();
        check("auto_off_hold", 32'(o_mode), 32'd2);
        i_auto = 1'b1;
        repeat (2) tick_valid();
        check("auto_restart_hold", 32'(o_mode), 32'd2);
        tick_valid();
        check("auto_restart_fire", 32'(o_mode), 32'd0);

        // Manual press in the same cycle as the auto tick.
        repeat (2) tick_valid();
        i_btn[0] = 1'b1;
        repeat (6) tick();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("collide_mode", 32'(o_mode), 32'd1);
        check("collide_clear", 32'(o_clear), 32'd1);
        i_btn[0] = 1'b0;
        repeat (2) tick_valid();
        check("collide_next_hold", 32'(o_mode), 32'd1);
        tick_valid();
        check("collide_next_fire", 32'(o_mode), 32'd2);

        // Button held through reset is a press once debounced after release.
        i_auto   = 1'b0;
        i_btn[0] = 1'b1;
        tick();
        i_reset = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        n    = 0;
        n_db = 0;
        while (o_mode != 2'd1 && n < 40) begin
            tick();
            n++;
            if (o_btn_db[0] && n_db == 0) n_db = n;
        end
        check("held_rst_db_latency", 32'(n_db), 32'(DEBOUNCE_MAX + 2));
        check("held_rst_mode_latency", 32'(n), 32'(DEBOUNCE_MAX + 3));
        i_btn = '0;
        repeat (10) tick();

        // Random stimulus checked every cycle against the model.
        foreach (hold_left[b]) hold_left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB_SW; b++) begin
                if (hold_left[b] == 0) begin
                    i_btn[b]     = 1'($urandom_range(0, 1));
                    hold_left[b] = int'($urandom_range(1, 10));
                end else begin
                    hold_left[b]--;
                end
            end
            i_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) i_auto = ~i_auto;
            i_reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        i_reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Control block for the LED pattern datapath (flash, shift register, two-LED shift) and the RGB colour selection. It synchronises and debounces the four push-buttons and turns their presses into single-cycle events. It sequences the working mode through a three-state FSM, either manually or automatically from counter ticks, and latches the selected colour. Its outputs drive the pattern mux select, the colour select and a restart pulse for the pattern generators.

Parameters:
NB_SW, 4, number of buttons (btn[0] = mode, btn[1..3] = red/green/blue).
NB_DEBOUNCE, 20, width of each per-button debounce counter.
DEBOUNCE_MAX, 1000000, consecutive differing cycles before a new button level is accepted; must be less than 2^NB_DEBOUNCE and at least 2.
NB_AUTO, 5, width of the auto-advance tick counter.
AUTO_TICKS, 16, number of i_valid ticks per automatic mode advance; must be between 1 and 2^NB_AUTO.

Ports:
clock  in  1  system clock; the only clock.
i_reset  in  1  asynchronous, active-high reset.
i_btn  in  NB_SW  raw button levels, asynchronous to clock.
i_valid  in  1  single-cycle tick from the count block.
i_auto  in  1  1 = automatic mode cycling enabled.
o_mode  out  2  working mode: 0 FLASH, 1 SHIFT, 2 SHIFT2.
o_color  out  2  colour: 0 RED, 1 GREEN, 2 BLUE.
o_clear  out  1  one-cycle restart pulse to the pattern blocks.
o_btn_db  out  NB_SW  debounced button levels, for LEDs and debug.

Behaviour:
- Reset (async assert, effective immediately, including mid-debounce or mid-auto-count): sync flops, stable levels, debounce counters and the auto counter go to 0; o_mode=FLASH, o_color=RED, o_clear=0, o_btn_db=0.
- Synchroniser: two flops per button, giving sync[i].
- Debounce, per button:
  - If sync equals stable, the counter goes to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_MAX-1 while sync still differs, stable takes sync and the counter goes to 0.
  - Any glitch shorter than DEBOUNCE_MAX cycles is ignored.
  - o_btn_db = stable.
- Press event: rise[i] = stable[i] AND NOT stable_q[i], one cycle wide. Only rising edges count; releases produce nothing. A button held through reset is seen as a press once it has been stable-high for DEBOUNCE_MAX cycles after reset deasserts.
- Latency: a raw level change that holds steady appears on o_btn_db exactly DEBOUNCE_MAX+2 cycles after the first clock edge that samples it. The resulting o_mode or o_color change appears one cycle after that.
- Mode FSM (registered o_mode):
  - Transitions: FLASH->SHIFT->SHIFT2->FLASH.
  - Advance event = rise[0] OR auto_fire.
  - A manual press and auto_fire in the same cycle advance by exactly one step.
  - Encoding 3 is illegal; if ever reached, the next state is FLASH and that transition counts as a change.
- Auto counter:
  - While i_auto=0 it is held at 0.
  - While i_auto=1, each i_valid increments it.
  - auto_fire = i_auto AND i_valid AND (counter == AUTO_TICKS-1); on fire the counter goes to 0.
  - rise[0] also clears the counter, so the next auto advance comes a full AUTO_TICKS after a manual press.
- o_clear: registered; high for exactly one cycle, the same cycle o_mode first shows a new value. Never asserted by colour changes or by reset.
- Colour (registered o_color):
  - rise[1] -> RED, rise[2] -> GREEN, rise[3] -> BLUE.
  - If several rise in the same cycle, lowest index wins.
  - With no rise, o_color holds.
  - Colour and mode events in the same cycle are independent; both update.
- Outputs change only on clock edges or asynchronously on reset; there are no combinational paths from input to output.

Decomposition:
- Package led_ctrl_pkg holds the mode encodings (MODE_FLASH=2'd0, MODE_SHIFT=2'd1, MODE_SHIFT2=2'd2), the colour encodings (COLOR_RED=2'd0, COLOR_GREEN=2'd1, COLOR_BLUE=2'd2) and the button index constants.
- One sub-module, btn_debounce (synchroniser + counter + stable flop for one button, parameterised by NB_DEBOUNCE and DEBOUNCE_MAX), instantiated NB_SW times with a generate loop.
- FSM, auto counter and colour register stay in led_mode_ctrl.

Test Plan:
Sim params: DEBOUNCE_MAX=4, AUTO_TICKS=3.
1. Reset mid-run: assert i_reset during an active debounce count and an active auto count -> o_mode=0, o_color=0, o_clear=0, o_btn_db=0 immediately; after release, a 2-cycle btn[0] glitch gives no o_mode change.
2. Manual cycling: hold btn[0] high for 6 cycles, four times, with gaps -> o_mode goes 1,2,0,1; o_clear high 1 cycle, exactly 7 cycles (DEBOUNCE_MAX+3) after each first sampling edge; releases give no event.
3. Colour select: press btn[2] -> o_color=1 with o_clear=0; press btn[1] and btn[3] together -> o_color=0; press btn[3] -> o_color=2.
4. Auto mode: i_auto=1 and i_valid every 5 cycles -> o_mode advances on every 3rd tick (0->1->2->0); set i_auto=0 -> o_mode holds, and re-enabling restarts the count from 0.
5. Collision: a btn[0] rise in the same cycle as auto_fire -> o_mode advances exactly one step, the auto counter is 0, and the next advance comes 3 ticks later.
6. Held through reset: btn[0] high before and after reset release -> o_btn_db[0]=1 and o_mode=1 once the press has been debounced (DEBOUNCE_MAX+3 cycles).
